jtag_tap_sampled: RTL and testbench
===================================

Name: jtag_tap_sampled

Overview:
- IEEE 1149.1 TAP controller clocked entirely on the CPU system clock. It sits directly downstream of the JTAG bitbang pins (tck/tms/tdi/trstn) and drives tdo.
- tck is oversampled as data; there is no second clock domain.
- Provides IDCODE, BYPASS and one user data register with a parallel capture/update handshake toward the debug module.

Parameters:
- IR_WIDTH, 5, instruction register width.
- IDCODE_VAL, 32'h10E3_1913, IDCODE value; bit0 must be 1.
- USER_DR_WIDTH, 41, user DR width (debug module interface).
- IR_IDCODE, 5'h01, IDCODE opcode.
- IR_USER, 5'h11, user DR opcode.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, asynchronous active-low reset.
- tck, input, 1, async JTAG clock, sampled.
- tms, input, 1, async JTAG mode select.
- tdi, input, 1, async JTAG data in.
- trstn, input, 1, async JTAG reset, active-low, sampled.
- tdo, output, 1, JTAG data out.
- tdo_en, output, 1, high while in Shift-IR/Shift-DR.
- user_capture_data, input, USER_DR_WIDTH, parallel value loaded in Capture-DR when IR=IR_USER.
- user_capture, output, 1, one-clk pulse when that capture occurs.
- user_update_data, output, USER_DR_WIDTH, shifted value, valid with user_update.
- user_update, output, 1, one-clk pulse on Update-DR when IR=IR_USER.
- ir_out, output, IR_WIDTH, current instruction.

Behaviour:
- **Synchronizers:** tck, tms, tdi and trstn each pass through 2-flop synchronizers. tck_rise/tck_fall come from a third registered tck copy.
  - Each event is a one-clk pulse, 3 clk after the pin edge.
  - tck high and low phases must each be ≥4 clk; shorter phases are undefined.
  - tms/tdi are taken from the synchronized copies on the same clk as tck_rise.
- **Reset (rstn low, async):**
  - Go to Test-Logic-Reset (TLR); IR=IR_IDCODE.
  - All shift registers 0; tdo=0; tdo_en=0.
  - user_capture=0, user_update=0, user_update_data=0.
- **TRST:** synchronized trstn low forces TLR and IR=IR_IDCODE on the next clk, regardless of tck. It has priority over tck_rise in the same clk.
- **FSM:** all 16 standard TAP states, advanced only on tck_rise using sampled tms.
  - Transitions are per 1149.1.
  - Five consecutive tck_rise with tms=1 reach TLR from any state.
  - Entering TLR loads IR=IR_IDCODE.
- **On tck_rise, by state:**
  - **Capture-IR:** ir_shift ← {IR_WIDTH-2 zeros, 2'b01}.
  - **Shift-IR:** ir_shift ← {tdi, ir_shift[IR_WIDTH-1:1]}.
  - **Update-IR:** IR ← ir_shift.
  - **Capture-DR:** selected DR loaded as follows.
    - IDCODE → IDCODE_VAL.
    - BYPASS → 0.
    - USER → user_capture_data, with a user_capture pulse in the same clk.
  - **Shift-DR:** selected DR shifts right, with tdi entering the MSB.
  - **Update-DR, IR=IR_USER:** user_update_data ← user shift register; user_update pulses 1 clk.
  - **Other opcodes:** any opcode other than IDCODE/USER selects BYPASS (1 bit).
- **tdo:** updated on tck_fall only. tdo ← LSB of the active shift register (IR in Shift-IR, selected DR in Shift-DR), else 0. tdo_en ← (state is Shift-IR or Shift-DR).
- **Simultaneous tck_rise and trst:** trst wins; no shift or update occurs.
- **rstn mid-shift:** partial shift is discarded; no user_update is emitted.
- **Glitch-free outputs:** all outputs are registered.

Test Plan:
- rstn low, release; 5 tck with tms=1, then tms=0 (Run-Test/Idle) → ir_out=5'h01, tdo=0, tdo_en=0, no user pulses.
- From reset, Capture-DR then 32 Shift-DR tck with tdi=0 → tdo sequence LSB-first reads 32'h10E3_1913; tdo_en=1 exactly across the shift.
- Shift-IR 5'h1F then Update-IR; Shift-DR pattern 1,0,1,1 → tdo returns 0,1,0,1 (one-bit delay); Capture-IR shift-out reads 5'b00001.
- IR=5'h11, user_capture_data=41'h1_2345_6789A; Capture-DR → user_capture one-clk pulse; shifting in 41'h0_0000_00055 shifts out 41'h1_2345_6789A; Update-DR → user_update pulse with user_update_data=41'h0_0000_00055.
- Mid-Shift-DR (IR=USER), drop trstn for 3 clk → state TLR, ir_out=5'h01, no user_update; next IDCODE read still returns 32'h10E3_1913.
- tck period 10 clk, tms toggling per tck: every state transition occurs exactly 3 clk after each tck rising pin edge; tdo changes exactly 3 clk after each falling pin edge.

Source files
------------

// File: rtl/jtag_tap_sampled.sv
// IEEE 1149.1 TAP controller that runs entirely on the system clock.
// tck/tms/tdi/trstn are oversampled, and TAP events are decoded from tck edges.
module jtag_tap_sampled #(
  parameter int                        IR_WIDTH      = 5,
  parameter logic [31:0]               IDCODE_VAL    = 32'h10E3_1913,
  parameter int                        USER_DR_WIDTH = 41,
  parameter logic [IR_WIDTH-1:0]       IR_IDCODE     = 5'h01,
  parameter logic [IR_WIDTH-1:0]       IR_USER       = 5'h11
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     tck,
  input  logic                     tms,
  input  logic                     tdi,
  input  logic                     trstn,
  output logic                     tdo,
  output logic                     tdo_en,
  input  logic [USER_DR_WIDTH-1:0] user_capture_data,
  output logic                     user_capture,
  output logic [USER_DR_WIDTH-1:0] user_update_data,
  output logic                     user_update,
  output logic [IR_WIDTH-1:0]      ir_out
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

  tap_state_e state, state_next;

  logic tck_s1, tck_s2, tck_s3;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic trstn_s1, trstn_s2;

  logic [IR_WIDTH-1:0]      ir, ir_shift;
  logic [31:0]              dr_idcode;
  logic                     dr_bypass;
  logic [USER_DR_WIDTH-1:0] dr_user;

  logic tck_rise, tck_fall, trst, step;
  logic sel_idcode, sel_user, dr_lsb;

  // The third tck copy gives edge detection; tms/tdi share the same depth as tck_s2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tck_s1   <= 1'b0;
      tck_s2   <= 1'b0;
      tck_s3   <= 1'b0;
      tms_s1   <= 1'b0;
      tms_s2   <= 1'b0;
      tdi_s1   <= 1'b0;
      tdi_s2   <= 1'b0;
      trstn_s1 <= 1'b0;
      trstn_s2 <= 1'b0;
    end else begin
      tck_s1   <= tck;
      tck_s2   <= tck_s1;
      tck_s3   <= tck_s2;
      tms_s1   <= tms;
      tms_s2   <= tms_s1;
      tdi_s1   <= tdi;
      tdi_s2   <= tdi_s1;
      trstn_s1 <= trstn;
      trstn_s2 <= trstn_s1;
    end
  end

  assign tck_rise   = tck_s2 & ~tck_s3;
  assign tck_fall   = ~tck_s2 & tck_s3;
  assign trst       = ~trstn_s2;
  assign step       = tck_rise & ~trst;
  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_user   = (ir == IR_USER);
  assign dr_lsb     = sel_idcode ? dr_idcode[0] : (sel_user ? dr_user[0] : dr_bypass);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= TLR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (trst) begin
      state_next = TLR;
    end else if (tck_rise) begin
      case (state)
        TLR:      state_next = tms_s2 ? TLR      : RTI;
        RTI:      state_next = tms_s2 ? SEL_DR   : RTI;
        SEL_DR:   state_next = tms_s2 ? SEL_IR   : CAP_DR;
        CAP_DR:   state_next = tms_s2 ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_next = tms_s2 ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_next = tms_s2 ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_next = tms_s2 ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_next = tms_s2 ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_next = tms_s2 ? SEL_DR   : RTI;
        SEL_IR:   state_next = tms_s2 ? TLR      : CAP_IR;
        CAP_IR:   state_next = tms_s2 ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_next = tms_s2 ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_next = tms_s2 ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_next = tms_s2 ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_next = tms_s2 ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_next = tms_s2 ? SEL_DR   : RTI;
        default:  state_next = TLR;
      endcase
    end
  end

  // Register actions key off the state being left on tck_rise; trst suppresses them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ir               <= IR_IDCODE;
      ir_shift         <= '0;
      dr_idcode        <= '0;
      dr_bypass        <= 1'b0;
      dr_user          <= '0;
      user_capture     <= 1'b0;
      user_update      <= 1'b0;
      user_update_data <= '0;
      tdo              <= 1'b0;
      tdo_en           <= 1'b0;
    end else begin
      user_capture <= 1'b0;
      user_update  <= 1'b0;
      if (step) begin
        case (state)
          CAP_IR:   ir_shift <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
          SHIFT_IR: ir_shift <= {tdi_s2, ir_shift[IR_WIDTH-1:1]};
          UPD_IR:   ir <= ir_shift;
          CAP_DR: begin
            if (sel_idcode) begin
              dr_idcode <= IDCODE_VAL;
            end else if (sel_user) begin
              dr_user      <= user_capture_data;
              user_capture <= 1'b1;
            end else begin
              dr_bypass <= 1'b0;
            end
          end
          SHIFT_DR: begin
            if (sel_idcode)    dr_idcode <= {tdi_s2, dr_idcode[31:1]};
            else if (sel_user) dr_user   <= {tdi_s2, dr_user[USER_DR_WIDTH-1:1]};
            else               dr_bypass <= tdi_s2;
          end
          UPD_DR: begin
            if (sel_user) begin
              user_update_data <= dr_user;
              user_update      <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (state_next == TLR) ir <= IR_IDCODE;
      if (tck_fall) begin
        tdo    <= (state == SHIFT_IR) ? ir_shift[0] : ((state == SHIFT_DR) ? dr_lsb : 1'b0);
        tdo_en <= (state == SHIFT_IR) || (state == SHIFT_DR);
      end
    end
  end

  assign ir_out = ir;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Self-checking bench for jtag_tap_sampled: directed and random JTAG scans
// compared against a table-driven TAP model and the expected register contents.
module tb_jtag_tap_sampled;

  logic        clk, rstn, tck, tms, tdi, trstn;
  logic        tdo, tdo_en, user_capture, user_update;
  logic [40:0] user_capture_data, user_update_data;
  logic [4:0]  ir_out;

  int tests = 0;
  int fails = 0;
  int cap_cnt = 0;
  int upd_cnt = 0;

  // Reference model: state numbers 0..15 = TLR,RTI,SelDR,CapDR,ShDR,Ex1DR,PauseDR,Ex2DR,
  // UpdDR,SelIR,CapIR,ShIR,Ex1IR,PauseIR,Ex2IR,UpdIR.
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int          m_state;
  logic [4:0]  m_ir, m_irsh;
  logic [63:0] m_dr;
  int          m_len;
  int          exp_cap, exp_upd;
  logic        exp_tdo, exp_en;

  jtag_tap_sampled dut (
    .clk(clk), .rstn(rstn), .tck(tck), .tms(tms), .tdi(tdi), .trstn(trstn),
    .tdo(tdo), .tdo_en(tdo_en),
    .user_capture_data(user_capture_data), .user_capture(user_capture),
    .user_update_data(user_update_data), .user_update(user_update),
    .ir_out(ir_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (user_capture) cap_cnt <= cap_cnt + 1;
    if (user_update)  upd_cnt <= upd_cnt + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ir = 5'h01; m_irsh = 5'h00; m_dr = 64'd0; m_len = 1;
    exp_tdo = 1'b0; exp_en = 1'b0;
  endtask

  task automatic model_step(input bit tms_v, input bit tdi_v);
    case (m_state)
      10: m_irsh = 5'h01;
      11: m_irsh = (m_irsh >> 1) | (5'(tdi_v) << 4);
      15: m_ir = m_irsh;
      3: begin
        if (m_ir == 5'h01) begin
          m_dr = 64'h10E3_1913; m_len = 32;
        end else if (m_ir == 5'h11) begin
          m_dr = 64'(user_capture_data); m_len = 41; exp_cap++;
        end else begin
          m_dr = 64'd0; m_len = 1;
        end
      end
      4: m_dr = (m_dr >> 1) | (64'(tdi_v) << (m_len - 1));
      8: if (m_ir == 5'h11) exp_upd++;
      default: ;
    endcase
    m_state = tms_v ? nxt1[m_state] : nxt0[m_state];
    if (m_state == 0) m_ir = 5'h01;
    exp_en  = (m_state == 11) || (m_state == 4);
    exp_tdo = (m_state == 11) ? m_irsh[0] : ((m_state == 4) ? m_dr[0] : 1'b0);
  endtask

  // One 10-clk tck period; checks ir_out and tdo land exactly 3 clk after each pin edge.
  task automatic applyStimulus(input bit tms_v, input bit tdi_v, output logic tdo_o);
    logic [4:0] ir_old;
    logic       tdo_old, en_old;
    ir_old = m_ir; tdo_old = exp_tdo; en_old = exp_en;
    @(negedge clk);
    tms = tms_v; tdi = tdi_v;
    repeat (2) @(negedge clk);
    tck = 1'b1;
    model_step(tms_v, tdi_v);
    repeat (2) @(posedge clk);
    #1 check("ir_before_rise_latency", 64'(ir_out), 64'(ir_old));
    @(posedge clk);
    #1 check("ir_after_rise_latency", 64'(ir_out), 64'(m_ir));
    repeat (3) @(negedge clk);
    tck = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("tdo_before_fall_latency", 64'(tdo), 64'(tdo_old));
    check("tdo_en_before_fall_latency", 64'(tdo_en), 64'(en_old));
    @(posedge clk);
    #1 check("tdo_after_fall_latency", 64'(tdo), 64'(exp_tdo));
    check("tdo_en_after_fall_latency", 64'(tdo_en), 64'(exp_en));
    tdo_o = tdo;
  endtask

  // Full scan starting and ending in Run-Test/Idle; dout is the LSB-first tdo stream.
  task automatic scan(input bit is_ir, input int len, input logic [63:0] din,
                      output logic [63:0] dout);
    logic cur, dummy;
    dout = 64'd0;
    applyStimulus(1'b1, 1'b0, dummy);
    if (is_ir) applyStimulus(1'b1, 1'b0, dummy);
    applyStimulus(1'b0, 1'b0, dummy);
    applyStimulus(1'b0, 1'b0, cur);
    for (int i = 0; i < len; i++) begin
      dout[i] = cur;
      applyStimulus(i == len - 1, din[i], cur);
    end
    applyStimulus(1'b1, 1'b0, dummy);
    applyStimulus(1'b0, 1'b0, dummy);
  endtask

  task automatic pulse_trstn();
    @(negedge clk);
    trstn = 1'b0;
    repeat (3) @(negedge clk);
    trstn = 1'b1;
    m_state = 0; m_ir = 5'h01;
    repeat (4) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input int cap_e, input int upd_e);
    check({tag, "_capture_pulses"}, 64'(cap_cnt), 64'(cap_e));
    check({tag, "_update_pulses"}, 64'(upd_cnt), 64'(upd_e));
  endtask

  initial begin
    logic [63:0] dout, din, exp_out;
    logic [4:0]  op;
    logic        dummy;
    int          len;

    tck = 1'b0; tms = 1'b0; tdi = 1'b0; trstn = 1'b1; rstn = 1'b0;
    user_capture_data = 41'd0;
    exp_cap = 0; exp_upd = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ir", 64'(ir_out), 64'h01);
    check("reset_tdo", 64'(tdo), 64'd0);
    check("reset_tdo_en", 64'(tdo_en), 64'd0);
    check("reset_update_data", 64'(user_update_data), 64'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Reset walk to Run-Test/Idle.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, dummy);
    applyStimulus(1'b0, 1'b0, dummy);
    check("rti_ir", 64'(ir_out), 64'h01);
    check("rti_tdo", 64'(tdo), 64'd0);
    check("rti_tdo_en", 64'(tdo_en), 64'd0);
    checkOutput("rti", 0, 0);

    // IDCODE read.
    scan(1'b0, 32, 64'd0, dout);
    check("idcode_read", dout, 64'h10E3_1913);

    // BYPASS via opcode 1F, including the Capture-IR pattern.
    scan(1'b1, 5, 64'h1F, dout);
    check("capture_ir_pattern", dout, 64'h01);
    check("ir_1f", 64'(ir_out), 64'h1F);
    scan(1'b0, 4, 64'b1101, dout);
    check("bypass_delay", dout, 64'b1010);

    // USER register capture / shift / update.
    scan(1'b1, 5, 64'h11, dout);
    check("ir_user", 64'(ir_out), 64'h11);
    user_capture_data = 41'h1_2345_6789A;
    scan(1'b0, 41, 64'h55, dout);
    check("user_shift_out", dout, 64'h1_2345_6789A);
    check("user_update_data", 64'(user_update_data), 64'h55);
    checkOutput("user", 1, 1);

    // trstn drop in the middle of a USER Shift-DR.
    applyStimulus(1'b1, 1'b0, dummy);
    applyStimulus(1'b0, 1'b0, dummy);
    applyStimulus(1'b0, 1'b0, dummy);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'($urandom_range(1)), dummy);
    pulse_trstn();
    check("trst_ir", 64'(ir_out), 64'h01);
    applyStimulus(1'b1, 1'b0, dummy);
    check("trst_tdo_en", 64'(tdo_en), 64'd0);
    applyStimulus(1'b0, 1'b0, dummy);
    checkOutput("trst", 2, 1);
    scan(1'b0, 32, 64'd0, dout);
    check("idcode_after_trst", dout, 64'h10E3_1913);

    // rstn drop in the middle of a USER Shift-DR.
    scan(1'b1, 5, 64'h11, dout);
    applyStimulus(1'b1, 1'b0, dummy);
    applyStimulus(1'b0, 1'b0, dummy);
    applyStimulus(1'b0, 1'b0, dummy);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, dummy);
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    #1 check("rstn_update_data", 64'(user_update_data), 64'd0);
    check("rstn_ir", 64'(ir_out), 64'h01);
    check("rstn_tdo_en", 64'(tdo_en), 64'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b0, dummy);
    checkOutput("rstn", 3, 1);

    // Random opcodes and data against the model.
    for (int r = 0; r < 6; r++) begin
      case (r % 3)
        0:       op = 5'h01;
        1:       op = 5'h11;
        default: op = 5'($urandom_range(31));
      endcase
      user_capture_data = {9'($urandom), $urandom};
      scan(1'b1, 5, 64'(op), dout);
      check("rand_capture_ir", dout, 64'h01);
      check("rand_ir", 64'(ir_out), 64'(op));
      len = (op == 5'h01) ? 32 : ((op == 5'h11) ? 41 : 8);
      din = {$urandom, $urandom} & ((64'd1 << len) - 64'd1);
      exp_out = (op == 5'h01) ? 64'h10E3_1913 :
                ((op == 5'h11) ? 64'(user_capture_data) : ((din << 1) & 64'hFF));
      scan(1'b0, len, din, dout);
      check("rand_dr_out", dout, exp_out);
      if (op == 5'h11) check("rand_update_data", 64'(user_update_data), din);
    end
    checkOutput("rand_scans", exp_cap, exp_upd);

    // Random tms walk, then five tms=1 must land in TLR from wherever it ended.
    for (int i = 0; i < 40; i++) applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), dummy);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, dummy);
    check("walk_tlr_ir", 64'(ir_out), 64'h01);
    check("walk_tlr_tdo_en", 64'(tdo_en), 64'd0);
    checkOutput("walk", exp_cap, exp_upd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
